// File: rtl/aes_pkg.sv
// Shared AES constants, FSM state type and byte-level GF(2^8) helpers used by
// the time-multiplexed SubBytes engine.
package aes_pkg;
  localparam int AES_BLOCK_W = 128;
  localparam int AES_BYTE_W  = 8;
  localparam int AES_BYTES   = AES_BLOCK_W / AES_BYTE_W;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Byte k of a block, byte 0 being the most significant.
  function automatic logic [AES_BYTE_W-1:0] byteSel(input logic [AES_BLOCK_W-1:0] w, input int k);
    return w[AES_BLOCK_W-1-AES_BYTE_W*k -: AES_BYTE_W];
  endfunction

  function automatic logic [7:0] gfMul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = '0;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // x^254 == x^-1 in GF(2^8); maps 0 to 0 as SubBytes requires.
  function automatic logic [7:0] gfInv(input logic [7:0] x);
    logic [7:0] x2, x3, x12, x15, x240;
    x2   = gfMul(x, x);
    x3   = gfMul(x2, x);
    x12  = gfMul(gfMul(x3, x3), gfMul(x3, x3));
    x15  = gfMul(x12, x3);
    x240 = gfMul(x15, x15);
    x240 = gfMul(x240, x240);
    x240 = gfMul(x240, x240);
    x240 = gfMul(x240, x240);
    return gfMul(gfMul(x240, x12), x2);
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    logic [15:0] t;
    t = {b, b} << n;
    return t[15:8];
  endfunction

  function automatic logic [7:0] sboxFwd(input logic [7:0] x);
    logic [7:0] v;
    v = gfInv(x);
    return v ^ rotl8(v, 1) ^ rotl8(v, 2) ^ rotl8(v, 3) ^ rotl8(v, 4) ^ 8'h63;
  endfunction

  function automatic logic [7:0] sboxInv(input logic [7:0] y);
    return gfInv(rotl8(y, 1) ^ rotl8(y, 3) ^ rotl8(y, 6) ^ 8'h05);
  endfunction
endpackage

// File: rtl/aes_sbox_lane.sv
// One byte lane: forward and inverse S-box side by side, selected by the
// block's latched mode.
module aes_sbox_lane
  import aes_pkg::*;
(
  input  logic       i_inv,
  input  logic [7:0] i_byte,
  output logic [7:0] o_byte
);
  logic [7:0] w_fwd;
  logic [7:0] w_inv;

  assign w_fwd  = sboxFwd(i_byte);
  assign w_inv  = sboxInv(i_byte);
  assign o_byte = i_inv ? w_inv : w_fwd;
endmodule

// File: rtl/aes_sub_bytes_seq.sv
// Time-multiplexed SubBytes/InvSubBytes: LANES bytes of the 128-bit state per
// clock, with valid/ready on both sides and a DONE->RUN path for back-to-back blocks.
module aes_sub_bytes_seq
  import aes_pkg::*;
#(
  parameter int LANES = 4
) (
  input  logic         clk,
  input  logic         rstN,
  input  logic         inValid,
  output logic         inReady,
  input  logic [127:0] inData,
  input  logic         inInverse,
  output logic         outValid,
  input  logic         outReady,
  output logic [127:0] outData,
  output logic         busy
);
  localparam int BEATS = AES_BYTES / LANES;
  localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(BEATS - 1);

  if (!(LANES == 1 || LANES == 2 || LANES == 4 || LANES == 8 || LANES == 16)) begin : g_bad_lanes
    $error("aes_sub_bytes_seq: LANES must be 1, 2, 4, 8 or 16");
  end

  state_t                r_state, w_next;
  logic [CNT_W-1:0]      r_cnt;
  logic [127:0]          r_work;
  logic [127:0]          r_res;
  logic                  r_inv;
  logic                  w_accept;
  logic                  w_last;
  logic [LANES-1:0][7:0] w_lane_in;
  logic [LANES-1:0][7:0] w_lane_out;

  assign w_accept = inValid && inReady;
  assign w_last   = (r_cnt == LAST);
  assign outData  = r_res;

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) r_state <= IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:    if (w_accept) w_next = RUN;
      RUN:     if (w_last) w_next = DONE;
      DONE:    if (outReady) w_next = inValid ? RUN : IDLE;
      default: w_next = IDLE;
    endcase
  end

  // In DONE the input side follows outReady so the next block can enter on
  // the same edge the finished one leaves.
  always_comb begin
    inReady  = 1'b0;
    outValid = 1'b0;
    busy     = 1'b0;
    case (r_state)
      IDLE:    inReady = rstN;
      RUN:     busy = 1'b1;
      DONE: begin
        inReady  = outReady;
        outValid = 1'b1;
        busy     = 1'b1;
      end
      default: ;
    endcase
  end

  always_comb begin
    w_lane_in = '0;
    for (int c = 0; c < BEATS; c++)
      if (r_cnt == CNT_W'(c))
        for (int l = 0; l < LANES; l++)
          w_lane_in[l] = byteSel(r_work, c * LANES + l);
  end

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    aes_sbox_lane u_lane (
      .i_inv  (r_inv),
      .i_byte (w_lane_in[g]),
      .o_byte (w_lane_out[g])
    );
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      r_cnt  <= '0;
      r_work <= '0;
      r_res  <= '0;
      r_inv  <= 1'b0;
    end else if (w_accept) begin
      r_work <= inData;
      r_inv  <= inInverse;
      r_cnt  <= '0;
    end else if (r_state == RUN) begin
      r_cnt <= w_last ? '0 : r_cnt + 1'b1;
      for (int b = 0; b < AES_BYTES; b++)
        if (r_cnt == CNT_W'(b / LANES))
          r_res[AES_BLOCK_W-1-AES_BYTE_W*b -: AES_BYTE_W] <= w_lane_out[b % LANES];
    end
  end
endmodule
